// File: rtl/ofc_pkg.sv
// Shared constants and types for the operand fetch controller.
// Optional writeback-to-operand forwarding is enabled by defining OFC_WB_FWD_EN.
package ofc_pkg;

   localparam int unsigned NREG = 16;
   localparam int unsigned AW   = 4;
   localparam int unsigned DW   = 32;

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StRead,
      StCapture,
      StOut
   } state_e;

   typedef struct packed {
      logic [AW-1:0] dest;
      logic [AW-1:0] src1;
      logic [AW-1:0] src2;
      logic          wen;
   } instr_t;

endpackage

// File: rtl/ofc_if.sv
// Bundle of the issue, register-bank, execute and writeback signals of the
// operand fetch controller. master = controller side, slave = environment side.
interface ofc_if;
   import ofc_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [AW-1:0]   in_dest;
   logic [AW-1:0]   in_src1;
   logic [AW-1:0]   in_src2;
   logic            in_wen;

   logic [AW-1:0]   rf_src1;
   logic [AW-1:0]   rf_src2;
   logic [DW-1:0]   rf_rdata1;
   logic [DW-1:0]   rf_rdata2;
   logic [AW-1:0]   rf_dest;
   logic [DW-1:0]   rf_wdata;
   logic            rf_we;

   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   out_op1;
   logic [DW-1:0]   out_op2;
   logic [AW-1:0]   out_dest;
   logic            out_wen;

   logic            wb_valid;
   logic [AW-1:0]   wb_dest;
   logic [DW-1:0]   wb_data;

   logic [NREG-1:0] busy_mask;

   modport master (
      input  in_valid, in_dest, in_src1, in_src2, in_wen,
      output in_ready,
      output rf_src1, rf_src2, rf_dest, rf_wdata, rf_we,
      input  rf_rdata1, rf_rdata2,
      output out_valid, out_op1, out_op2, out_dest, out_wen,
      input  out_ready,
      input  wb_valid, wb_dest, wb_data,
      output busy_mask
   );

   modport slave (
      output in_valid, in_dest, in_src1, in_src2, in_wen,
      input  in_ready,
      input  rf_src1, rf_src2, rf_dest, rf_wdata, rf_we,
      output rf_rdata1, rf_rdata2,
      input  out_valid, out_op1, out_op2, out_dest, out_wen,
      output out_ready,
      output wb_valid, wb_dest, wb_data,
      input  busy_mask
   );

endinterface

// File: rtl/ofc_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// writeback. A set and clear of the same bit on one edge leaves it set.
module ofc_scoreboard
   import ofc_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            set_en,
   input  logic [AW-1:0]   set_idx,
   input  logic            clr_en,
   input  logic [AW-1:0]   clr_idx,
   output logic [NREG-1:0] mask
);

   logic [NREG-1:0] mask_q, mask_d;

   // Next mask: apply clear first so a simultaneous set overrides it.
   always_comb begin
      mask_d = mask_q;
      if (clr_en) mask_d[clr_idx] = 1'b0;
      if (set_en) mask_d[set_idx] = 1'b1;
   end

   // Mask register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mask_q <= '0;
      else        mask_q <= mask_d;
   end

   assign mask = mask_q;

endmodule

// File: rtl/operand_fetch_ctrl.sv
// Operand fetch controller: accepts decoded instructions, stalls on RAW/WAW
// hazards against the pending-write scoreboard, reads the register bank and
// hands the operand pair to execute. Writebacks pass straight to the bank.
// Define OFC_WB_FWD_EN to forward a same-cycle writeback into a stalled source.
module operand_fetch_ctrl
   import ofc_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   ofc_if.master bus
);

   state_e          state_q, state_d;
   instr_t          instr_q, instr_d;
   logic [DW-1:0]   op1_q, op1_d, op2_q, op2_d;
   logic [NREG-1:0] busy;
   logic            sb_set;
   logic            pend1, pend2, hazard;
   logic [DW-1:0]   cap1, cap2;

`ifdef OFC_WB_FWD_EN
   logic          hit1, hit2;
   logic          fwd1_vld_q, fwd1_vld_d, fwd2_vld_q, fwd2_vld_d;
   logic [DW-1:0] fwd1_q, fwd1_d, fwd2_q, fwd2_d;

   assign hit1 = bus.wb_valid && (bus.wb_dest == instr_q.src1);
   assign hit2 = bus.wb_valid && (bus.wb_dest == instr_q.src2);

   // Re-evaluate forwards every CHECK cycle so only the leaving cycle counts.
   always_comb begin
      fwd1_vld_d = fwd1_vld_q;
      fwd2_vld_d = fwd2_vld_q;
      fwd1_d     = fwd1_q;
      fwd2_d     = fwd2_q;
      if (state_q == StCheck) begin
         fwd1_vld_d = hit1;
         fwd2_vld_d = hit2;
         if (hit1) fwd1_d = bus.wb_data;
         if (hit2) fwd2_d = bus.wb_data;
      end
   end

   // Forward registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd1_vld_q <= 1'b0;
         fwd2_vld_q <= 1'b0;
         fwd1_q     <= '0;
         fwd2_q     <= '0;
      end else begin
         fwd1_vld_q <= fwd1_vld_d;
         fwd2_vld_q <= fwd2_vld_d;
         fwd1_q     <= fwd1_d;
         fwd2_q     <= fwd2_d;
      end
   end

   assign pend1 = busy[instr_q.src1] & ~hit1;
   assign pend2 = busy[instr_q.src2] & ~hit2;
   assign cap1  = fwd1_vld_q ? fwd1_q : bus.rf_rdata1;
   assign cap2  = fwd2_vld_q ? fwd2_q : bus.rf_rdata2;
`else
   assign pend1 = busy[instr_q.src1];
   assign pend2 = busy[instr_q.src2];
   assign cap1  = bus.rf_rdata1;
   assign cap2  = bus.rf_rdata2;
`endif

   // Registered scoreboard only; a bit cleared at an edge is seen next cycle.
   assign hazard = pend1 | pend2 | (instr_q.wen & busy[instr_q.dest]);

   // Next-state, instruction latch and operand capture.
   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      sb_set  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               instr_d = '{dest: bus.in_dest, src1: bus.in_src1,
                           src2: bus.in_src2, wen: bus.in_wen};
               state_d = StCheck;
            end
         end
         StCheck: begin
            if (!hazard) state_d = StRead;
         end
         StRead: begin
            sb_set  = instr_q.wen;
            state_d = StCapture;
         end
         StCapture: begin
            op1_d   = cap1;
            op2_d   = cap2;
            state_d = StOut;
         end
         StOut: begin
            if (bus.out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State, instruction and operand registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         instr_q <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
      end
   end

   ofc_scoreboard u_scoreboard (
      .clk     (clk),
      .rst_n   (rst_n),
      .set_en  (sb_set),
      .set_idx (instr_q.dest),
      .clr_en  (bus.wb_valid),
      .clr_idx (bus.wb_dest),
      .mask    (busy)
   );

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StOut);
   assign bus.out_op1   = op1_q;
   assign bus.out_op2   = op2_q;
   assign bus.out_dest  = instr_q.dest;
   assign bus.out_wen   = instr_q.wen;
   assign bus.rf_src1   = instr_q.src1;
   assign bus.rf_src2   = instr_q.src2;
   assign bus.rf_we     = bus.wb_valid;
   assign bus.rf_dest   = bus.wb_dest;
   assign bus.rf_wdata  = bus.wb_data;
   assign bus.busy_mask = busy;

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Bench for operand_fetch_ctrl: register-bank model, directed scenarios and a
// randomized program checked against sequential-execution semantics.
module tb_operand_fetch_ctrl;
   import ofc_pkg::*;

   typedef struct {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [3:0]  dest;
      logic        wen;
      logic [31:0] wdata;
   } exp_t;

   typedef struct {
      logic [3:0]  dest;
      logic [31:0] data;
   } wb_t;

   logic clk = 1'b0;
   logic rst_n;
   ofc_if bus ();

   operand_fetch_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   exp_t        exp_q[$];
   wb_t         wb_q[$];
   logic [31:0] mem[16];        // bank contents
   logic [31:0] arch[16];       // program-order register values incl. promised writes
   logic [31:0] committed[16];  // values actually written back so far
   bit          auto_wb  = 0;
   bit          wb_rand  = 0;
   int          ready_mode = 1; // 0 hold low, 1 hold high, 2 random
   bit          timeout  = 0;
   int          lat;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Register bank: synchronous write, registered read.
   initial for (int i = 0; i < 16; i++) mem[i] = 32'h11 * i;
   always @(posedge clk) begin
      if (bus.rf_we) mem[bus.rf_dest] <= bus.rf_wdata;
      bus.rf_rdata1 <= mem[bus.rf_src1];
      bus.rf_rdata2 <= mem[bus.rf_src2];
   end

   // Writeback driver, changes on the falling edge.
   initial begin
      wb_t w;
      bus.wb_valid = 1'b0;
      bus.wb_dest  = '0;
      bus.wb_data  = '0;
      forever begin
         @(negedge clk);
         if (wb_q.size() > 0 && (!wb_rand || $urandom_range(0, 2) == 0)) begin
            w = wb_q.pop_front();
            bus.wb_valid = 1'b1;
            bus.wb_dest  = w.dest;
            bus.wb_data  = w.data;
            committed[w.dest] = w.data;
         end else begin
            bus.wb_valid = 1'b0;
         end
      end
   end

   // Execute-side ready driver.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: every execute handshake is checked against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out_valid", 32'(bus.out_valid), 32'h0);
            end else begin
               e = exp_q.pop_front();
               chk("out_op1", bus.out_op1, e.op1);
               chk("out_op2", bus.out_op2, e.op2);
               chk("out_dest", 32'(bus.out_dest), 32'(e.dest));
               chk("out_wen", 32'(bus.out_wen), 32'(e.wen));
               if (auto_wb && e.wen) wb_q.push_back('{dest: e.dest, data: e.wdata});
            end
         end
      end
   end

   // Present one instruction (called just after a rising edge); returns after acceptance.
   task automatic issue(input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2,
                        input logic w, input logic [31:0] wd);
      exp_t e;
      int   cnt = 0;
      e.op1 = arch[s1];
      e.op2 = arch[s2];
      e.dest = d;
      e.wen = w;
      e.wdata = wd;
      if (w) arch[d] = wd;
      exp_q.push_back(e);
      bus.in_valid = 1'b1;
      bus.in_dest  = d;
      bus.in_src1  = s1;
      bus.in_src2  = s2;
      bus.in_wen   = w;
      while (!bus.in_ready && cnt < 300) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      if (!bus.in_ready) begin
         chk("accept_timeout", 32'(bus.in_ready), 32'h1);
         timeout = 1;
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_dest  = 4'($urandom);
      bus.in_src1  = 4'($urandom);
      bus.in_src2  = 4'($urandom);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!bus.out_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic drain();
      int cnt = 0;
      while ((exp_q.size() != 0 || !bus.in_ready) && cnt < 500) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      if (cnt >= 500) chk("drain_timeout", 32'(exp_q.size()), 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         arch[i]      = 32'h11 * i;
         committed[i] = 32'h11 * i;
      end
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_dest = '0;
      bus.in_src1 = '0;
      bus.in_src2 = '0;
      bus.in_wen = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_busy", 32'(bus.busy_mask), 32'h0);
      chk("rst_out_op1", bus.out_op1, 32'h0);
      chk("rst_rf_we", 32'(bus.rf_we), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic issue: latency, read selects, operands, scoreboard bit.
      issue(4'd3, 4'd1, 4'd2, 1'b1, 32'hDEADBEEF);
      @(posedge clk);
      #1;
      chk("read_rf_src1", 32'(bus.rf_src1), 32'h1);
      chk("read_rf_src2", 32'(bus.rf_src2), 32'h2);
      wait_valid(lat);
      chk("issue_latency", 32'(lat + 1), 32'h3);
      chk("busy_after_issue", 32'(bus.busy_mask), 32'h0008);
      drain();

      // RAW stall on r3 until its writeback.
      issue(4'd9, 4'd3, 4'd0, 1'b0, 32'h0);
      repeat (5) @(posedge clk);
      #1;
      chk("raw_stall_valid", 32'(bus.out_valid), 32'h0);
      chk("raw_stall_in_ready", 32'(bus.in_ready), 32'h0);
      chk("raw_stall_busy", 32'(bus.busy_mask), 32'h0008);
      wb_q.push_back('{dest: 4'd3, data: 32'hDEADBEEF});
      @(negedge clk);
      #1;
      chk("wb_rf_we", 32'(bus.rf_we), 32'h1);
      chk("wb_rf_dest", 32'(bus.rf_dest), 32'h3);
      chk("wb_rf_wdata", bus.rf_wdata, 32'hDEADBEEF);
      @(posedge clk);
      #1;
      chk("wb_busy_clear", 32'(bus.busy_mask), 32'h0);
      drain();

      // WAW stall on r5; a non-writing instruction to r5 does not stall.
      issue(4'd5, 4'd0, 4'd0, 1'b1, 32'h55AA55AA);
      drain();
      chk("waw_busy", 32'(bus.busy_mask), 32'h0020);
      issue(4'd5, 4'd1, 4'd2, 1'b1, 32'h12345678);
      repeat (6) @(posedge clk);
      #1;
      chk("waw_stall_valid", 32'(bus.out_valid), 32'h0);
      wb_q.push_back('{dest: 4'd5, data: 32'h55AA55AA});
      drain();
      chk("waw_reissue_busy", 32'(bus.busy_mask), 32'h0020);
      issue(4'd5, 4'd6, 4'd7, 1'b0, 32'h0);
      wait_valid(lat);
      chk("nowen_latency", 32'(lat), 32'h3);
      drain();
      wb_q.push_back('{dest: 4'd5, data: 32'h12345678});
      repeat (3) @(posedge clk);
      #1;
      chk("waw_final_busy", 32'(bus.busy_mask), 32'h0);

      // Backpressure: outputs hold while out_ready is low.
      ready_mode = 0;
      issue(4'd2, 4'd1, 4'd3, 1'b0, 32'h0);
      wait_valid(lat);
      for (int i = 0; i < 4; i++) begin
         chk("hold_valid", 32'(bus.out_valid), 32'h1);
         chk("hold_op1", bus.out_op1, exp_q[0].op1);
         chk("hold_op2", bus.out_op2, exp_q[0].op2);
         chk("hold_in_ready", 32'(bus.in_ready), 32'h0);
         @(posedge clk);
         #1;
      end
      ready_mode = 1;
      @(posedge clk);
      #2;
      @(posedge clk);
      #1;
      chk("release_in_ready", 32'(bus.in_ready), 32'h1);
      chk("release_out_valid", 32'(bus.out_valid), 32'h0);
      drain();

      // Reset during CAPTURE with r4, r5 pending.
      issue(4'd4, 4'd0, 4'd0, 1'b1, 32'hCAFE0004);
      drain();
      issue(4'd5, 4'd0, 4'd0, 1'b1, 32'hCAFE0005);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("capture_busy", 32'(bus.busy_mask), 32'h0030);
      rst_n = 1'b0;
      exp_q.delete();
      wb_q.delete();
      for (int i = 0; i < 16; i++) arch[i] = committed[i];
      #1;
      chk("midrst_busy", 32'(bus.busy_mask), 32'h0);
      chk("midrst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Writeback arriving during a RAW stall on src2.
      issue(4'd7, 4'd0, 4'd0, 1'b1, 32'hA5A5A5A5);
      drain();
      issue(4'd8, 4'd1, 4'd7, 1'b0, 32'h0);
      wb_q.push_back('{dest: 4'd7, data: 32'hA5A5A5A5});
      wait_valid(lat);
`ifdef OFC_WB_FWD_EN
      chk("fwd_latency", 32'(lat), 32'h3);
`else
      chk("wb_stall_latency", 32'(lat), 32'h4);
`endif
      drain();

      // Randomized program with random writeback and execute timing.
      auto_wb    = 1;
      wb_rand    = 1;
      ready_mode = 2;
      for (int n = 0; n < 150 && !timeout; n++) begin
         issue(4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), $urandom);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      begin
         int cnt = 0;
         while ((exp_q.size() != 0 || wb_q.size() != 0 || !bus.in_ready) && cnt < 3000) begin
            @(posedge clk);
            #1;
            cnt++;
         end
         chk("random_drain", 32'(exp_q.size() + wb_q.size()), 32'h0);
      end
      repeat (3) @(posedge clk);
      #1;
      chk("final_busy", 32'(bus.busy_mask), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/operand_fetch_ctrl.md
Name: operand_fetch_ctrl

Overview:
Initiator-side controller for the 16x32 register bank (`Register_bank`): it drives the bank's read selects, write dest and write data.
- Accepts decoded instructions (dest, src1, src2) through a valid/ready handshake.
- Tracks pending writes in a 16-bit scoreboard and stalls on RAW/WAW hazards.
- Issues reads to the bank and returns the operand pair to execute.
- Writeback results return to this block, which forwards them to the bank write port.

Parameters:
NREG, 16, number of architectural registers
AW, 4, register index width (log2 NREG)
DW, 32, data width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decoded instruction valid
in_ready  out  1  controller can accept instruction
in_dest  in  AW  destination register index
in_src1  in  AW  first source index
in_src2  in  AW  second source index
in_wen  in  1  instruction writes in_dest
rf_src1  out  AW  to bank Source1
rf_src2  out  AW  to bank Source2
rf_rdata1  in  DW  from bank Result_1 (registered in bank, 1-cycle latency)
rf_rdata2  in  DW  from bank Result_2
rf_dest  out  AW  to bank Dest
rf_wdata  out  DW  to bank ldr_in
rf_we  out  1  bank write strobe
out_valid  out  1  operands valid to execute
out_ready  in  1  execute accepts
out_op1  out  DW  operand 1
out_op2  out  DW  operand 2
out_dest  out  AW  carried destination
out_wen  out  1  carried write flag
wb_valid  in  1  writeback result valid (always accepted)
wb_dest  in  AW  writeback register
wb_data  in  DW  writeback data
busy_mask  out  NREG  current scoreboard

Behaviour:
- Reset (async, rst_n=0):
  - Go to IDLE; scoreboard = 0.
  - All outputs 0 except in_ready = 1.
  - Reset mid-operation drops the held instruction and all pending bits.
- FSM states: IDLE, CHECK, READ, CAPTURE, OUT.
- IDLE:
  - in_ready = 1.
  - On in_valid, latch dest/src1/src2/wen and go to CHECK.
  - in_ready = 0 in every other state.
- CHECK:
  - hazard = sb[src1] | sb[src2] | (wen & sb[dest]), evaluated on the registered scoreboard.
  - If hazard, stay in CHECK. A bit cleared at edge T is seen as clear at T+1; there is no same-cycle bypass.
  - If no hazard, go to READ.
- READ:
  - Drive rf_src1/rf_src2 with the latched indices; rf_src outputs hold these values through CAPTURE.
  - If wen, set sb[dest] on leaving READ.
  - Go to CAPTURE.
- CAPTURE:
  - Register rf_rdata1/2 into out_op1/2.
  - Go to OUT.
- OUT:
  - out_valid = 1; operands and dest/wen are stable until the handshake.
  - On out_ready, drop out_valid and go to IDLE.
- Minimum issue latency: accept edge to out_valid = 3 cycles.
- Writeback (any state):
  - When wb_valid: rf_we = 1, rf_dest = wb_dest, rf_wdata = wb_data in the same cycle (combinational pass-through).
  - Clear sb[wb_dest] at the edge.
  - If the edge leaving READ sets sb[X] while wb clears sb[X] on the same edge, the set wins.
- src1 == src2 is legal and produces one hazard term.
- dest == src is legal; hazard is checked before the dest bit is set.
- wb_valid for a register whose scoreboard bit is clear: the bank is still written; the bit stays 0.

Optional Feature:
- Macro: `OFC_WB_FWD_EN`
- Defined:
  - In CHECK, a hazard on srcN is resolved in the same cycle when wb_valid && wb_dest == srcN. The pending bit for that source is ignored and wb_data is captured into a forward register for operand N.
  - In CAPTURE, out_opN takes the forwarded value instead of rf_rdataN.
  - Saves at least 1 stall cycle.
- Undefined: no forward path; behaviour exactly as above.

Decomposition:
- Package ofc_pkg:
  - NREG/AW/DW constants.
  - State enum {IDLE, CHECK, READ, CAPTURE, OUT}.
  - Instruction struct {dest, src1, src2, wen}.
- One natural sub-module, ofc_scoreboard:
  - Inputs: set index/enable, clear index/enable.
  - Output: the 16-bit mask, with set-over-clear priority.

Test Plan:
- Reset then issue {dest=3, src1=1, src2=2, wen=1} with bank r1=0x11, r2=0x22 -> out_valid 3 cycles after accept; op1=0x11, op2=0x22, out_dest=3; busy_mask=0x0008.
- With sb[3] pending, issue src1=3 -> stall in CHECK. Then wb_valid dest=3 data=0xDEADBEEF -> rf_we pulse, mask clears, operand later reads 0xDEADBEEF.
- WAW: pending dest 5, new instruction dest=5 wen=1 -> stalls until wb on r5; wen=0 with the same dest -> no stall.
- Hold out_ready=0 for 4 cycles -> out_valid and operands stable, in_ready stays 0. Assert out_ready -> IDLE next cycle.
- Drive rst_n low during CAPTURE with sb=0x0030 -> mask=0, out_valid=0 immediately, in_ready=1.
- With `OFC_WB_FWD_EN`: hazard on src2=7 plus same-cycle wb dest=7 data=0xA5A5A5A5 -> no extra stall, op2=0xA5A5A5A5.
